// File: rtl/mp_pkg.sv
// Shared constants for the interrupt controller: source count, vector base,
// acknowledge timeout, FSM state encoding and the fixed-priority encoder.
package mp_pkg;

   localparam int unsigned N_SRC       = 4;
   localparam int unsigned ID_W        = 2;
   localparam logic [7:0]  VEC_BASE    = 8'hE0;
   localparam int unsigned ACK_TIMEOUT = 16;
   localparam int unsigned TO_W        = 4;

   typedef logic [1:0] state_t;

   localparam state_t StIdle    = 2'd0;
   localparam state_t StAssert  = 2'd1;
   localparam state_t StService = 2'd2;

   // Lowest set index wins; returns 0 when nothing is requested.
   function automatic logic [ID_W-1:0] prio_id(input logic [N_SRC-1:0] req);
      logic [ID_W-1:0] id;
      id = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (req[i]) id = ID_W'(i);
      end
      return id;
   endfunction

endpackage

// File: rtl/irq_edge_detect.sv
// Per-source registered rising-edge detector.
// Ports:
//   clk   - clock
//   reset - asynchronous active-low reset
//   src   - raw interrupt source levels
//   rise  - one-cycle rising-edge flags (combinational from src and its registered copy)
module irq_edge_detect #(
   parameter int unsigned N_SRC = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_SRC-1:0] src,
   output logic [N_SRC-1:0] rise
);

   logic [N_SRC-1:0] src_q;
   logic             armed_q;

   // armed_q stays low for the first cycle after reset release so sources
   // already high at release are captured as history, not seen as edges.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         src_q   <= '0;
         armed_q <= 1'b0;
      end else begin
         src_q   <= src;
         armed_q <= 1'b1;
      end
   end

   assign rise = armed_q ? (src & ~src_q) : '0;

endmodule

// File: rtl/interrupt_controller.sv
// Four-source edge-triggered interrupt controller with fixed priority, mask,
// acknowledge timeout and a non-nesting service phase.
// Ports:
//   clk, reset          - clock, asynchronous active-low reset
//   irq_src             - rising-edge triggered sources (bit 0 highest priority)
//   mask_wr, mask_in    - mask register write (1 = masked)
//   irq_ack, eoi        - core acknowledge / end-of-interrupt pulses
//   interrupt           - level request to the core
//   vector, active_id   - jump address and index of the granted source
//   busy                - request outstanding or in service
//   pending             - pending register
import mp_pkg::*;

module interrupt_controller (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_SRC-1:0] irq_src,
   input  logic             mask_wr,
   input  logic [N_SRC-1:0] mask_in,
   input  logic             irq_ack,
   input  logic             eoi,
   output logic             interrupt,
   output logic [7:0]       vector,
   output logic [ID_W-1:0]  active_id,
   output logic             busy,
   output logic [N_SRC-1:0] pending
);

   localparam logic [TO_W-1:0] ToLast = TO_W'(ACK_TIMEOUT - 1);

   state_t           state_q, state_d;
   logic [N_SRC-1:0] pending_q, pending_d;
   logic [N_SRC-1:0] mask_q;
   logic [ID_W-1:0]  id_q, id_d;
   logic [TO_W-1:0]  cnt_q, cnt_d;
   logic [N_SRC-1:0] rise;
   logic [N_SRC-1:0] clr;

   irq_edge_detect #(
      .N_SRC (N_SRC)
   ) u_edge (
      .clk   (clk),
      .reset (reset),
      .src   (irq_src),
      .rise  (rise)
   );

   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      cnt_d   = cnt_q;
      clr     = '0;
      case (state_q)
         StIdle: begin
            if (|(pending_q & ~mask_q)) begin
               id_d    = prio_id(pending_q & ~mask_q);
               cnt_d   = '0;
               state_d = StAssert;
            end
         end
         StAssert: begin
            if (irq_ack) begin
               clr[id_q] = 1'b1;
               state_d   = StService;
            end else if (cnt_q == ToLast) begin
               // Give up on the core; the source stays pending for re-arbitration.
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + TO_W'(1);
            end
         end
         StService: begin
            if (eoi) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      // A new edge in the clear cycle keeps the bit set.
      pending_d = (pending_q & ~clr) | rise;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         pending_q <= '0;
         mask_q    <= '1;
         id_q      <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         id_q      <= id_d;
         cnt_q     <= cnt_d;
         if (mask_wr) mask_q <= mask_in;
      end
   end

   assign interrupt = (state_q == StAssert);
   assign busy      = (state_q == StAssert) || (state_q == StService);
   assign active_id = id_q;
   assign vector    = VEC_BASE + {4'b0000, id_q, 2'b00};
   assign pending   = pending_q;

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-003 SHALL have port irq_src, input, 4, external interrupt sources, one bit per source, rising-edge triggered.
REQ-004 SHALL have port mask_wr, input, 1, write strobe for the mask register.
REQ-005 SHALL have port mask_in, input, 4, new mask value (1 = source masked).
REQ-006 SHALL have port irq_ack, input, 1, single-cycle pulse from the core when it takes the interrupt.
REQ-007 SHALL have port eoi, input, 1, single-cycle end-of-interrupt pulse from the core.
REQ-008 SHALL have port interrupt, output, 1, level request to the core's interrupt input.
REQ-009 SHALL have port vector, output, 8, jump address for the granted source.
REQ-010 SHALL have port active_id, output, 2, index of the granted or in-service source.
REQ-011 SHALL have port busy, output, 1, high while a request is outstanding or in service.
REQ-012 SHALL have port pending, output, 4, current pending register.

Function
REQ-013 SHALL register irq_src each cycle; an edge is detected when the registered value is 0 and the current value is 1.
REQ-014 SHALL set pending[i] on the cycle after an edge on source i, regardless of mask.
REQ-015 SHALL give priority to the lowest index: source 0 is highest, source 3 lowest.
REQ-016 SHALL implement an FSM with states IDLE, ASSERT and SERVICE.
REQ-017 IDLE: when (pending & ~mask) != 0, latch the highest-priority id into active_id and go to ASSERT; interrupt=1 from the next cycle.
REQ-018 ASSERT: hold interrupt=1 and hold vector/active_id stable until irq_ack.
REQ-019 ASSERT: on irq_ack, clear pending[active_id], drop interrupt the next cycle, and go to SERVICE.
REQ-020 ASSERT: if irq_ack is absent for ACK_TIMEOUT=16 consecutive cycles, drop interrupt, keep pending, and return to IDLE; 1-cycle gap before re-arbitration.
REQ-021 SERVICE: interrupt=0 and busy=1; on eoi go to IDLE; no nesting, so higher-priority pendings wait.
REQ-022 SHALL ignore irq_ack outside ASSERT and eoi outside SERVICE.
REQ-023 SHALL compute vector = VEC_BASE (8'hE0) + {active_id, 2'b00}, giving E0/E4/E8/EC.
REQ-024 SHALL let set win over clear when the same pending bit receives an edge in the clear cycle, so the bit remains pending.
REQ-025 SHALL update mask on the cycle after mask_wr; a mask change during ASSERT or SERVICE does not cancel the current grant.
REQ-026 SHALL drive busy=1 exactly when the state is ASSERT or SERVICE.
REQ-027 SHALL implement the timeout counter as 4 bits, cleared on ASSERT entry, saturating on expiry (never wraps).

Reset
REQ-028 SHALL, on reset low, immediately set: state=IDLE, interrupt=0, busy=0, pending=0, active_id=0, vector=8'hE0, mask=4'b1111 (all masked), edge registers=0, timeout counter=0.
REQ-029 SHALL, on reset asserted mid-ASSERT or mid-SERVICE, abandon the grant and lose all pendings.
REQ-030 SHALL, on reset deassertion, not treat sources already high as edges.

Structure
REQ-031 SHALL place N_SRC=4, VEC_BASE=8'hE0, ACK_TIMEOUT=16 and the state encoding in shared package mp_pkg.
REQ-032 SHALL instantiate one sub-module, irq_edge_detect (per-source registered rising-edge detector, width parameter N_SRC).

Verification
REQ-033 SHALL cover: mask=0, pulse irq_src[2] -> pending=0100, interrupt high 2 cycles later, vector=E8; ack -> pending=0, SERVICE; eoi -> IDLE, busy=0.
REQ-034 SHALL cover: edges on sources 3 and 1 in the same cycle -> grant id=1 (vector E4); after ack+eoi -> grant id=3 (vector EC).
REQ-035 SHALL cover: mask=4'b1111, edge on source 0 -> pending=0001, interrupt stays 0; write mask=0 -> interrupt rises, vector=E0.
REQ-036 SHALL cover: no ack for 16 cycles -> interrupt drops, pending retained, re-asserted after 1 idle cycle.
REQ-037 SHALL cover: new edge on source 2 coincident with ack of source 2 -> pending[2] stays 1, re-granted after eoi.
REQ-038 SHALL cover: reset low during SERVICE with pending=1010 -> all outputs at reset values immediately; sources held high produce no grant after release.
